// File: rtl/exec_pkg.sv
// exec_pkg: shared ALU opcode encodings, datapath width and flag bit positions
package exec_pkg;
    localparam int DATA_W = 16;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOR   = 4'h5,
        OP_NOT   = 4'h6,
        OP_SLL   = 4'h7,
        OP_SRL   = 4'h8,
        OP_SRA   = 4'h9,
        OP_MUL   = 4'hA,
        OP_SLT   = 4'hB,
        OP_SLTU  = 4'hC,
        OP_PASSA = 4'hD,
        OP_PASSB = 4'hE,
        OP_INC   = 4'hF
    } alu_op_e;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational 16-op ALU producing a result and {N,Z,C,V} flags
module alu_core
    import exec_pkg::*;
(
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] res_o,
    output logic [3:0]        flags_o
);
    logic [DATA_W:0] wide;
    logic            c;
    logic            v;

    always_comb begin
        wide  = '0;
        res_o = '0;
        c     = 1'b0;
        v     = 1'b0;
        case (op_i)
            OP_ADD: begin
                wide  = {1'b0, a_i} + {1'b0, b_i};
                res_o = wide[DATA_W-1:0];
                c     = wide[DATA_W];
                v     = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (res_o[DATA_W-1] != a_i[DATA_W-1]);
            end
            OP_SUB: begin
                res_o = a_i - b_i;
                c     = a_i < b_i;
                v     = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (res_o[DATA_W-1] != a_i[DATA_W-1]);
            end
            OP_AND:   res_o = a_i & b_i;
            OP_OR:    res_o = a_i | b_i;
            OP_XOR:   res_o = a_i ^ b_i;
            OP_NOR:   res_o = ~(a_i | b_i);
            OP_NOT:   res_o = ~a_i;
            // the extra guard bit catches the last bit shifted out (stays 0 for a zero shift)
            OP_SLL: begin
                wide  = {1'b0, a_i} << b_i[3:0];
                res_o = wide[DATA_W-1:0];
                c     = wide[DATA_W];
            end
            OP_SRL: begin
                wide  = {a_i, 1'b0} >> b_i[3:0];
                res_o = wide[DATA_W:1];
                c     = wide[0];
            end
            OP_SRA: begin
                wide  = $signed({a_i, 1'b0}) >>> b_i[3:0];
                res_o = wide[DATA_W:1];
                c     = wide[0];
            end
            OP_MUL:   res_o = a_i * b_i;
            OP_SLT:   res_o = DATA_W'($signed(a_i) < $signed(b_i));
            OP_SLTU:  res_o = DATA_W'(a_i < b_i);
            OP_PASSA: res_o = a_i;
            OP_PASSB: res_o = b_i;
            OP_INC: begin
                wide  = {1'b0, a_i} + (DATA_W+1)'(1);
                res_o = wide[DATA_W-1:0];
                c     = wide[DATA_W];
                v     = !a_i[DATA_W-1] && res_o[DATA_W-1];
            end
            default: res_o = '0;
        endcase
        flags_o         = '0;
        flags_o[FLAG_N] = res_o[DATA_W-1];
        flags_o[FLAG_Z] = res_o == '0;
        flags_o[FLAG_C] = c;
        flags_o[FLAG_V] = v;
    end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: Decode/Execute register, ALU and Execute/Memory register of the 16-bit pipeline
module execute_stage #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   alu_op_in,
    input  logic [DATA_W-1:0] src_a_in,
    input  logic [DATA_W-1:0] src_b_in,
    output logic [OP_W-1:0]   alu_op_ex,
    output logic [DATA_W-1:0] src_a_ex,
    output logic [DATA_W-1:0] src_b_ex,
    output logic [DATA_W-1:0] alu_result_ex,
    output logic [3:0]        alu_flags_ex,
    output logic [DATA_W-1:0] alu_result_mem,
    output logic [3:0]        alu_flags_mem
);
    import exec_pkg::*;

    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q, res_d, res_q;
    logic [3:0]        flags_d, flags_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            op_q <= alu_op_in;
            a_q  <= src_a_in;
            b_q  <= src_b_in;
        end
    end

    alu_core u_alu (
        .op_i    (alu_op_e'(op_q[3:0])),
        .a_i     (a_q),
        .b_i     (b_q),
        .res_o   (res_d),
        .flags_o (flags_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign alu_op_ex      = op_q;
    assign src_a_ex       = a_q;
    assign src_b_ex       = b_q;
    assign alu_result_ex  = res_d;
    assign alu_flags_ex   = flags_d;
    assign alu_result_mem = res_q;
    assign alu_flags_mem  = flags_q;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: random and directed stimulus checked against an integer-arithmetic ALU model
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] alu_op_in, src_a_in, src_b_in;
    logic [15:0] alu_op_ex, src_a_ex, src_b_ex, alu_result_ex, alu_result_mem;
    logic [3:0]  alu_flags_ex, alu_flags_mem;

    int n_vec = 0;
    int n_err = 0;

    execute_stage #(.DATA_W(16), .OP_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_op_in      (alu_op_in),
        .src_a_in       (src_a_in),
        .src_b_in       (src_b_in),
        .alu_op_ex      (alu_op_ex),
        .src_a_ex       (src_a_ex),
        .src_b_ex       (src_b_ex),
        .alu_result_ex  (alu_result_ex),
        .alu_flags_ex   (alu_flags_ex),
        .alu_result_mem (alu_result_mem),
        .alu_flags_mem  (alu_flags_mem)
    );

    always #5 clk = ~clk;

    // returns {N,Z,C,V, result} computed with plain integer arithmetic
    function automatic logic [19:0] ref_alu(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        int     s  = int'(b[3:0]);
        longint r  = 0;
        logic   c  = 1'b0;
        logic   v  = 1'b0;
        logic [15:0] res;
        case (op[3:0])
            4'h0: begin r = ua + ub; c = r > 65535; v = (sa + sb > 32767) || (sa + sb < -32768); end
            4'h1: begin r = ua - ub; c = ua < ub; v = (sa - sb > 32767) || (sa - sb < -32768); end
            4'h2: r = ua & ub;
            4'h3: r = ua | ub;
            4'h4: r = ua ^ ub;
            4'h5: r = ~(ua | ub);
            4'h6: r = ~ua;
            4'h7: begin r = ua << s; c = (s != 0) && (((ua >> (16 - s)) & 1) == 1); end
            4'h8: begin r = ua >> s; c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
            4'h9: begin r = sa >>> s; c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
            4'hA: r = ua * ub;
            4'hB: r = (sa < sb) ? 1 : 0;
            4'hC: r = (ua < ub) ? 1 : 0;
            4'hD: r = ua;
            4'hE: r = ub;
            default: begin r = ua + 1; c = r > 65535; v = sa == 32767; end
        endcase
        res = r[15:0];
        return {res[15], res == 16'h0, c, v, res};
    endfunction

    // model of what sits in each stage, advanced on the same events as the pipeline
    logic [15:0] m_op = '0, m_a = '0, m_b = '0;
    logic [19:0] m_mem = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_op  = '0;
            m_a   = '0;
            m_b   = '0;
            m_mem = '0;
        end else begin
            m_mem = ref_alu(m_op, m_a, m_b);
            m_op  = alu_op_in;
            m_a   = src_a_in;
            m_b   = src_b_in;
        end
    end

    always @(negedge clk) begin
        logic [19:0] e;
        e = ref_alu(m_op, m_a, m_b);
        n_vec++;
        if ({alu_op_ex, src_a_ex, src_b_ex} !== {m_op, m_a, m_b}) begin
            n_err++;
            $display("FAIL ex_regs: got op=%h a=%h b=%h want op=%h a=%h b=%h", alu_op_ex, src_a_ex, src_b_ex, m_op, m_a, m_b);
        end
        if ({alu_flags_ex, alu_result_ex} !== e) begin
            n_err++;
            $display("FAIL alu_ex: op=%h a=%h b=%h got res=%h fl=%b want res=%h fl=%b", m_op, m_a, m_b, alu_result_ex, alu_flags_ex, e[15:0], e[19:16]);
        end
        if ({alu_flags_mem, alu_result_mem} !== m_mem) begin
            n_err++;
            $display("FAIL mem: got res=%h fl=%b want res=%h fl=%b", alu_result_mem, alu_flags_mem, m_mem[15:0], m_mem[19:16]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b);
        alu_op_in = op;
        src_a_in  = a;
        src_b_in  = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        alu_op_in = 16'h0001;
        src_a_in  = 16'h1234;
        src_b_in  = 16'h5678;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regs", {alu_op_ex, src_a_ex, src_b_ex}, 32'h0);
        chk("rst_mem", {12'h0, alu_flags_mem, alu_result_mem}, 32'h0);
        chk("rst_ex", {12'h0, alu_flags_ex, alu_result_ex}, {12'h0, 4'b0100, 16'h0000});
        reset = 1'b1;

        apply(16'h0000, 16'h0005, 16'h0003);
        chk("add_ex", {alu_flags_ex, alu_result_ex}, {4'b0000, 16'h0008});
        apply(16'hFFF0, 16'h7FFF, 16'h0001);
        chk("add_mem", {alu_flags_mem, alu_result_mem}, {4'b0000, 16'h0008});
        chk("add_ovf", {alu_flags_ex, alu_result_ex}, {4'b1001, 16'h8000});
        apply(16'h0001, 16'h0000, 16'h0001);
        chk("sub_borrow", {alu_flags_ex, alu_result_ex}, {4'b1010, 16'hFFFF});
        apply(16'h0007, 16'h8001, 16'h0001);
        chk("sll", {alu_flags_ex, alu_result_ex}, {4'b0010, 16'h0002});
        apply(16'h0008, 16'h8001, 16'h0001);
        chk("srl", {alu_flags_ex, alu_result_ex}, {4'b0010, 16'h4000});
        apply(16'h0009, 16'h8001, 16'h0001);
        chk("sra", {alu_flags_ex, alu_result_ex}, {4'b1010, 16'hC000});
        apply(16'h0007, 16'h8001, 16'h0010);
        chk("sll_by0", {alu_flags_ex, alu_result_ex}, {4'b1000, 16'h8001});

        apply(16'h0000, 16'h0001, 16'h0001);
        apply(16'h0001, 16'h0005, 16'h0007);
        chk("stream0", {alu_flags_mem, alu_result_mem}, {4'b0000, 16'h0002});
        apply(16'h000A, 16'h0100, 16'h0100);
        chk("stream1", {16'h0, alu_result_mem}, {16'h0, 16'hFFFE});
        apply(16'h000B, 16'hFFFF, 16'h0001);
        chk("stream2", {alu_flags_mem, alu_result_mem}, {4'b0100, 16'h0000});
        apply(16'h000D, 16'h1234, 16'h0000);
        chk("stream3", {alu_flags_mem, alu_result_mem}, {4'b0000, 16'h0001});

        for (int i = 0; i < 600; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 3))
                0: a = 16'h7FFF;
                1: b = 16'h8000;
                2: b = a;
                default: ;
            endcase
            apply(16'($urandom), a, b);
        end

        apply(16'h0000, 16'h4321, 16'h1111);
        #2;
        reset = 1'b0;
        #1;
        chk("async_regs", {alu_op_ex, src_a_ex, src_b_ex}, 32'h0);
        chk("async_mem", {12'h0, alu_flags_mem, alu_result_mem}, 32'h0);
        chk("async_ex", {12'h0, alu_flags_ex, alu_result_ex}, {12'h0, 4'b0100, 16'h0000});
        @(posedge clk);
        #2;
        reset = 1'b1;
        apply(16'h000F, 16'h7FFF, 16'h0000);
        chk("inc_ovf", {alu_flags_ex, alu_result_ex}, {4'b1001, 16'h8000});
        apply(16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
